// File: rtl/clock_display_pkg.sv
// ---------------------------------------------------------------------------
// clock_display_pkg
//
// Shared definitions for the 7-segment clock display front end:
//   - seq_state_e   : state encoding of the MAX7219 frame sequencer
//   - MAX7219_BLANK : code-B nibble that lights no segments
//   - MAX_DIGITS    : number of digit registers on a MAX7219
//   - pack_segment  : builds the data byte sent for one digit
// ---------------------------------------------------------------------------
package clock_display_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CFG_ISSUE = 3'd1,
    ST_CFG_WAIT  = 3'd2,
    ST_DIG_ISSUE = 3'd3,
    ST_DIG_WAIT  = 3'd4,
    ST_DONE      = 3'd5
  } seq_state_e;

  localparam logic [3:0] MAX7219_BLANK = 4'hF;
  localparam int         MAX_DIGITS    = 8;

  // Data byte for a code-B digit: DP in bit 7, bits 6:4 unused (zero),
  // the BCD/code-B nibble in bits 3:0.
  function automatic logic [7:0] pack_segment(input logic dp, input logic [3:0] nib);
    return {dp, 3'b000, nib};
  endfunction

endpackage

// File: rtl/max7219_digit_mux.sv
// ---------------------------------------------------------------------------
// max7219_digit_mux
//
// Combinational selector: picks the nibble and decimal point of one digit
// out of a packed snapshot and formats the MAX7219 data byte.
//
// Build option (macro):
//   SEQ_BLANK_LEADING_ZERO_EN - when defined, a zero in the most significant
//     digit (index NUM_DIGITS-1) is replaced by the code-B blank nibble.
//     The decimal point of that digit is passed through unchanged.
//
// Ports:
//   bcd_i      packed digits, digit k at [4k+3:4k], digit 0 rightmost
//   dp_i       decimal point per digit
//   idx_i      digit index to select (always < NUM_DIGITS in use)
//   segment_o  {dp, 3'b000, nibble}
// ---------------------------------------------------------------------------
module max7219_digit_mux
  import clock_display_pkg::*;
#(
  parameter int NUM_DIGITS = 6
) (
  input  logic [4*NUM_DIGITS-1:0] bcd_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [2:0]              idx_i,
  output logic [7:0]              segment_o
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  logic [3:0] nib;
  logic       dp;

  always_comb begin
    nib = 4'h0;
    dp  = 1'b0;
    // Compare-and-select loop keeps every slice constant, so no
    // out-of-range part-select exists for NUM_DIGITS below 8.
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_i == 3'(k)) begin
        nib = bcd_i[4*k +: 4];
        dp  = dp_i[k];
      end
    end
`ifdef SEQ_BLANK_LEADING_ZERO_EN
    if ((idx_i == LAST_IDX) && (nib == 4'h0)) begin
      nib = MAX7219_BLANK;
    end
`else
    // Every nibble goes out unmodified; LAST_IDX is only needed for blanking.
    if (idx_i == LAST_IDX) begin
      nib = nib;
    end
`endif
    segment_o = pack_segment(dp, nib);
  end

endmodule

// File: rtl/max7219_frame_sequencer.sv
// ---------------------------------------------------------------------------
// max7219_frame_sequencer
//
// Upstream sequencer for the 7-segment clock display. Snapshots a packed BCD
// digit vector plus decimal-point mask and walks it into max7219_settings one
// digit per transaction. A configuration write is issued before the first
// frame after reset and before any frame requested through i_config_change.
//
// Build option (macro):
//   SEQ_BLANK_LEADING_ZERO_EN - blank a zero in digit NUM_DIGITS-1
//     (handled in max7219_digit_mux).
//
// Handshake with max7219_settings (valid/ready style):
//   o_stb is the request and is held high, with o_write_config/o_digit/
//   o_segment stable, until i_busy is sampled high (request accepted). The
//   sequencer then waits for i_busy to fall; i_ack sampled in that same cycle
//   says whether the write completed (1) or must be retried (0). o_stb is
//   decoded from registered state only, so there is no combinational path
//   from i_busy/i_ack to any output.
//
// Ports:
//   i_clk, i_reset_n      clock, asynchronous active-low reset
//   i_refresh             one-cycle request for a frame
//   i_config_change       one-cycle request for config write + frame
//   i_bcd, i_dp_mask      digits and decimal points, sampled at frame start
//   o_busy                a config or frame sequence is in progress
//   o_frame_done          one-cycle pulse after the last digit is acked
//   o_stb, o_write_config, o_digit, o_segment  request to max7219_settings
//   i_busy, i_ack         status from max7219_settings
// ---------------------------------------------------------------------------
module max7219_frame_sequencer
  import clock_display_pkg::*;
#(
  parameter int NUM_DIGITS = 6
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_refresh,
  input  logic                    i_config_change,
  input  logic [4*NUM_DIGITS-1:0] i_bcd,
  input  logic [NUM_DIGITS-1:0]   i_dp_mask,
  output logic                    o_busy,
  output logic                    o_frame_done,
  output logic                    o_stb,
  output logic                    o_write_config,
  output logic [2:0]              o_digit,
  output logic [7:0]              o_segment,
  input  logic                    i_busy,
  input  logic                    i_ack
);

  if ((NUM_DIGITS < 1) || (NUM_DIGITS > MAX_DIGITS)) begin : g_bad_num_digits
    $error("max7219_frame_sequencer: NUM_DIGITS must be 1..8");
  end

  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  seq_state_e              state_q, state_d;
  logic                    cfg_pend_q, cfg_pend_d;
  logic                    frm_pend_q, frm_pend_d;
  logic [2:0]              idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;

  logic                    cfg_clr;
  logic                    frm_clr;
  logic [7:0]              mux_segment;

  // -------------------------------------------------------------------------
  // Digit formatting from the snapshot (never from the live i_bcd)
  // -------------------------------------------------------------------------
  max7219_digit_mux #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_digit_mux (
    .bcd_i     (bcd_q),
    .dp_i      (dp_q),
    .idx_i     (idx_q),
    .segment_o (mux_segment)
  );

  // -------------------------------------------------------------------------
  // State and data registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      // Both flags start set: the first sequence after reset is a config
      // write followed by a full frame, with no request needed.
      cfg_pend_q <= 1'b1;
      frm_pend_q <= 1'b1;
      idx_q      <= 3'd0;
      bcd_q      <= '0;
      dp_q       <= '0;
    end else begin
      state_q    <= state_d;
      cfg_pend_q <= cfg_pend_d;
      frm_pend_q <= frm_pend_d;
      idx_q      <= idx_d;
      bcd_q      <= bcd_d;
      dp_q       <= dp_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next state, pending flags and output decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    bcd_d          = bcd_q;
    dp_d           = dp_q;
    cfg_clr        = 1'b0;
    frm_clr        = 1'b0;
    o_busy         = 1'b1;
    o_frame_done   = 1'b0;
    o_stb          = 1'b0;
    o_write_config = 1'b0;
    o_digit        = idx_q;
    o_segment      = 8'h00;

    unique case (state_q)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (cfg_pend_q) begin
          // frm_pend stays set, so returning to IDLE after the config
          // write launches the frame.
          cfg_clr = 1'b1;
          state_d = ST_CFG_ISSUE;
        end else if (frm_pend_q) begin
          frm_clr = 1'b1;
          bcd_d   = i_bcd;
          dp_d    = i_dp_mask;
          idx_d   = 3'd0;
          state_d = ST_DIG_ISSUE;
        end
      end

      ST_CFG_ISSUE: begin
        o_stb          = 1'b1;
        o_write_config = 1'b1;
        if (i_busy) begin
          state_d = ST_CFG_WAIT;
        end
      end

      ST_CFG_WAIT: begin
        if (!i_busy) begin
          state_d = i_ack ? ST_IDLE : ST_CFG_ISSUE;
        end
      end

      ST_DIG_ISSUE: begin
        o_stb     = 1'b1;
        o_segment = mux_segment;
        if (i_busy) begin
          state_d = ST_DIG_WAIT;
        end
      end

      ST_DIG_WAIT: begin
        // Digit and segment stay on the bus while the write is in flight.
        o_segment = mux_segment;
        if (!i_busy) begin
          if (!i_ack) begin
            state_d = ST_DIG_ISSUE;
          end else if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_DIG_ISSUE;
          end
        end
      end

      ST_DONE: begin
        o_frame_done = 1'b1;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A request arriving in the same cycle the flag is consumed wins, so it
    // produces exactly one further sequence. Repeated requests coalesce.
    cfg_pend_d = (cfg_pend_q & ~cfg_clr) | i_config_change;
    frm_pend_d = (frm_pend_q & ~frm_clr) | i_refresh | i_config_change;
  end

endmodule

// File: doc/max7219_frame_sequencer.md
# max7219_frame_sequencer

Upstream frame sequencer for the 7-segment clock display. It snapshots a packed BCD digit vector and walks it into `max7219_settings` one digit per transaction. A configuration write precedes the first frame after reset and any frame requested with a config change. It sits between the timekeeping logic and `max7219_settings`, driving that block's stb/busy/ack handshake.

## Interface
**Parameters**
- `NUM_DIGITS`, default 6: digits written per frame; legal range 1..8.

**Ports**
- `i_clk` in 1: system clock (~50 MHz).
- `i_reset_n` in 1: reset; asynchronous, active-low.
- `i_refresh` in 1: one-cycle request to write a frame.
- `i_config_change` in 1: one-cycle request to rewrite config before the next frame; also requests a frame.
- `i_bcd` in 4*NUM_DIGITS: digit k at `[4k+3:4k]`; digit 0 is rightmost.
- `i_dp_mask` in NUM_DIGITS: decimal point per digit.
- `o_busy` out 1: a config or frame sequence is in progress.
- `o_frame_done` out 1: one-cycle pulse after the last digit is acked.
- `o_stb` out 1: to `max7219_settings` `i_stb`.
- `o_write_config` out 1: to `i_write_config`.
- `o_digit` out 3: to `i_digit`.
- `o_segment` out 8: to `i_segment`; bit 7 = DP, bits 3:0 = code-B nibble, bits 6:4 = 0.
- `i_busy` in 1: from `o_busy` of `max7219_settings`.
- `i_ack` in 1: from `o_ack` of `max7219_settings`.

## Operation
- **States:** IDLE, CFG_ISSUE, CFG_WAIT, DIG_ISSUE, DIG_WAIT, DONE.
- **Pending flags:** `cfg_pend` and `frm_pend` reset to 1, so the first sequence after reset is a config write followed by a full frame.
  - `i_refresh` sets `frm_pend`. `i_config_change` sets both flags. Requests are honoured in any state.
  - A flag set during a sequence causes exactly one further sequence. Multiple requests coalesce.
- **IDLE:**
  - If `cfg_pend`: go to CFG_ISSUE and clear `cfg_pend`.
  - Else if `frm_pend`: snapshot `i_bcd`/`i_dp_mask` into internal registers, clear `frm_pend`, set the index to 0, go to DIG_ISSUE.
- **CFG_ISSUE:** `o_stb=1`, `o_write_config=1`. Go to CFG_WAIT the cycle `i_busy=1` is sampled.
- **CFG_WAIT:** `o_stb=0`. When `i_busy=0`:
  - `i_ack=1`: go to IDLE. The still-set `frm_pend` starts the frame.
  - `i_ack=0`: go back to CFG_ISSUE (retry).
- **DIG_ISSUE:** `o_stb=1`, `o_write_config=0`, `o_digit`=index, `o_segment={dp[idx],3'b0,nib[idx]}`. Go to DIG_WAIT when `i_busy=1`.
- **DIG_WAIT:** `o_stb=0`. Hold `o_digit`/`o_segment` stable. When `i_busy=0`:
  - `i_ack=1` and index = NUM_DIGITS-1: go to DONE.
  - `i_ack=1` otherwise: increment the index, go to DIG_ISSUE.
  - `i_ack=0`: retry the same digit via DIG_ISSUE.
- **DONE:** `o_frame_done=1` for one cycle, then go to IDLE.
- **Snapshot:** digit values come from the snapshot only; `i_bcd` changes mid-frame do not affect the current frame.
- **Index width:** 3 bits. The index never exceeds NUM_DIGITS-1 (no wrap).

## Timing
- **Reset values:** `o_busy=0`, `o_frame_done=0`, `o_stb=0`, `o_write_config=0`, `o_digit=0`, `o_segment=8'h00`. State is IDLE, both pending flags are 1, index is 0.
- All outputs are registered or decoded from registered state. No combinational path from `i_busy`/`i_ack` to `o_stb`.
- `o_busy=1` in every state except IDLE.
- **Latency:** `i_refresh` in IDLE → `o_stb` high 2 cycles later: flag set, then IDLE → DIG_ISSUE.
- `o_stb` stays high until `i_busy` is sampled high, then drops in the same cycle the state leaves ISSUE.
- **Reset asserted mid-sequence:**
  - Outputs return to reset values immediately.
  - The sequence restarts from config after release.
  - Any partial frame is abandoned.

## Configuration
- **`SEQ_BLANK_LEADING_ZERO_EN` defined:** when the snapshot nibble of digit NUM_DIGITS-1 is 0, it is sent as 4'hF (code-B blank). DP is unaffected.
- **Not defined:** every nibble is sent unmodified.

## Structure
- **Shared package `clock_display_pkg`:**
  - state enum;
  - `MAX7219_BLANK = 4'hF`;
  - `MAX_DIGITS = 8`.
- **Sub-module `max7219_digit_mux`:** combinational. Selects nibble and DP by index and applies leading-zero blanking under the macro.
- **Bench:** instantiate with real `max7219_settings` + `max7219` as the downstream.

## Test plan
- **Reset release:** no stimulus → one config transaction (`o_write_config=1`), then digits 0..5. Segments match reset-time `i_bcd=24'h123456`: digit 0 = 8'h06 … digit 5 = 8'h01. Then one `o_frame_done` pulse.
- **Refresh:** `i_bcd=24'h095930`, `i_dp_mask=6'b000100`, pulse `i_refresh` → six writes with no config write. Digit 2 segment = 8'h89.
- **Mid-frame input change:** change `i_bcd` mid-frame → the current frame uses the old snapshot. A second `i_refresh` during the frame produces exactly one extra frame.
- **Config change:** pulse `i_config_change` while idle → config write precedes the frame. Two pulses within one frame → exactly one config + one frame afterwards.
- **Retry:** force `i_ack=0` on the digit-3 completion → digit 3 is re-issued and the frame still completes with 6 acked digits.
- **Leading-zero blanking:** with `SEQ_BLANK_LEADING_ZERO_EN` and `i_bcd=24'h012345`, digit 5 segment = 8'h0F. Without the macro it is 8'h00.
